// File: rtl/cdc_sync_filt.sv
// cdc_sync_filt
// ---------------------------------------------------------------------------
// Multi-bit synchroniser for asynchronous level inputs (buttons, strobes,
// status lines from other clock domains). Each bit passes through a chain of
// STAGES-1 flops. A per-bit stability filter sits after the chain and drives q.
// Registered rise/fall pulses are optional.
//
// Parameters
//   WIDTH     : number of independent bits
//   STAGES    : flops from d to q when FILTER = 0 (minimum 2)
//   FILTER    : extra consecutive cycles a new value must hold before q takes it
//   RESET_VAL : reset value of every chain stage and of q
//
// Ports
//   clk     in   destination clock
//   rst_n   in   synchronous, active-low reset
//   d       in   [WIDTH] asynchronous input; bits are unrelated
//   q       out  [WIDTH] synchronised, filtered level
//   rise    out  [WIDTH] one-cycle pulse when q goes 0->1
//   fall    out  [WIDTH] one-cycle pulse when q goes 1->0
//   changed out  OR of all rise and fall bits, coincident with them
//
// Build option
//   CDC_SYNC_FILT_EDGE_EN : when defined, the rise/fall/changed registers are
//   built. When undefined, those outputs are tied to 0. q behaves the same in
//   both builds.
// ---------------------------------------------------------------------------
module cdc_sync_filt #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter int               FILTER    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int NS = STAGES - 1;
  localparam int CW = (FILTER == 0) ? 1 : $clog2(FILTER + 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_sync_filt: STAGES must be at least 2");
  end

  // Synchroniser chain. sync_q[0] samples d; s is the last flop.
  logic [WIDTH-1:0] sync_q [NS];
  logic [WIDTH-1:0] s;

  assign s = sync_q[NS-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) sync_q[k] <= RESET_VAL;
    end else begin
      sync_q[0] <= d;
      for (int k = 1; k < NS; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Stability filter. cnt[i] counts the cycles s[i] has disagreed with q[i].
  // It saturates at FILTER, where the next disagreeing cycle makes q take the
  // value. Any agreeing cycle clears the count, so glitches shorter than
  // FILTER+1 cycles never reach q.
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s[i] != q[i]) begin
        if (cnt[i] == CW'(FILTER)) q_next[i] = s[i];
        else                       cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      q <= q_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

`ifdef CDC_SYNC_FILT_EDGE_EN
  // Pulses are computed from q_next, so they register on the same edge as q
  // and show in the first cycle q holds its new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      rise    <= q_next & ~q;
      fall    <= ~q_next & q;
      changed <= |(q_next ^ q);
    end
  end
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_sync_filt.sv
// Testbench for cdc_sync_filt. It uses two instances:
//   dut_a : WIDTH=4, STAGES=3, FILTER=3, RESET_VAL=4'b1010
//   dut_b : WIDTH=2, STAGES=2, FILTER=0, RESET_VAL=2'b00
// A reference model applies the rule "q takes s once s has disagreed with q
// on FILTER+1 consecutive edges" using a history of s values. Directed
// checks cover reset, latency and glitch rejection.
module tb_cdc_sync_filt;

  localparam int        A_ST = 3;
  localparam int        A_F  = 3;
  localparam logic [3:0] A_RV = 4'b1010;
  localparam int        B_ST = 2;
  localparam int        B_F  = 0;
  localparam logic [1:0] B_RV = 2'b00;

`ifdef CDC_SYNC_FILT_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] d_a = 4'b0000;
  logic [3:0] q_a, rise_a, fall_a;
  logic       chg_a;
  logic [1:0] d_b = 2'b11;
  logic [1:0] q_b, rise_b, fall_b;
  logic       chg_b;

  cdc_sync_filt #(.WIDTH(4), .STAGES(A_ST), .FILTER(A_F), .RESET_VAL(A_RV)) dut_a (
    .clk(clk), .rst_n(rst_n), .d(d_a), .q(q_a), .rise(rise_a), .fall(fall_a), .changed(chg_a)
  );

  cdc_sync_filt #(.WIDTH(2), .STAGES(B_ST), .FILTER(B_F), .RESET_VAL(B_RV)) dut_b (
    .clk(clk), .rst_n(rst_n), .d(d_b), .q(q_b), .rise(rise_b), .fall(fall_b), .changed(chg_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each chain holds d samples, newest at index 0. Each hist holds the s
  // values seen at recent edges, newest at index 0.
  logic [3:0] ma_chain [A_ST-1];
  logic [3:0] ma_hist  [A_F+1];
  logic [3:0] ma_q, ma_rise, ma_fall;
  logic       ma_chg;
  logic [1:0] mb_chain [B_ST-1];
  logic [1:0] mb_hist  [B_F+1];
  logic [1:0] mb_q, mb_rise, mb_fall;
  logic       mb_chg;

  initial begin
    logic [3:0] sa, qna;
    logic [1:0] sb, qnb;
    bit all_diff;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        foreach (ma_chain[k]) ma_chain[k] = A_RV;
        foreach (ma_hist[k])  ma_hist[k]  = A_RV;
        ma_q = A_RV; ma_rise = '0; ma_fall = '0; ma_chg = 1'b0;
        foreach (mb_chain[k]) mb_chain[k] = B_RV;
        foreach (mb_hist[k])  mb_hist[k]  = B_RV;
        mb_q = B_RV; mb_rise = '0; mb_fall = '0; mb_chg = 1'b0;
      end else begin
        // instance A
        sa = ma_chain[A_ST-2];
        for (int k = A_ST-2; k > 0; k--) ma_chain[k] = ma_chain[k-1];
        ma_chain[0] = d_a;
        for (int k = A_F; k > 0; k--) ma_hist[k] = ma_hist[k-1];
        ma_hist[0] = sa;
        qna = ma_q;
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          for (int k = 0; k <= A_F; k++) if (ma_hist[k][i] == ma_q[i]) all_diff = 1'b0;
          if (all_diff) qna[i] = sa[i];
        end
        ma_rise = EDGE_EN ? (qna & ~ma_q) : 4'b0;
        ma_fall = EDGE_EN ? (~qna & ma_q) : 4'b0;
        ma_chg  = EDGE_EN && (qna != ma_q);
        ma_q    = qna;
        // instance B
        sb = mb_chain[B_ST-2];
        for (int k = B_ST-2; k > 0; k--) mb_chain[k] = mb_chain[k-1];
        mb_chain[0] = d_b;
        for (int k = B_F; k > 0; k--) mb_hist[k] = mb_hist[k-1];
        mb_hist[0] = sb;
        qnb = mb_q;
        for (int i = 0; i < 2; i++) begin
          all_diff = 1'b1;
          for (int k = 0; k <= B_F; k++) if (mb_hist[k][i] == mb_q[i]) all_diff = 1'b0;
          if (all_diff) qnb[i] = sb[i];
        end
        mb_rise = EDGE_EN ? (qnb & ~mb_q) : 2'b0;
        mb_fall = EDGE_EN ? (~qnb & mb_q) : 2'b0;
        mb_chg  = EDGE_EN && (qnb != mb_q);
        mb_q    = qnb;
      end
    end
  end

  // Compare on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("q_a",    32'(q_a),    32'(ma_q));
        check("rise_a", 32'(rise_a), 32'(ma_rise));
        check("fall_a", 32'(fall_a), 32'(ma_fall));
        check("chg_a",  32'(chg_a),  32'(ma_chg));
        check("q_b",    32'(q_b),    32'(mb_q));
        check("rise_b", 32'(rise_b), 32'(mb_rise));
        check("fall_b", 32'(fall_b), 32'(mb_fall));
        check("chg_b",  32'(chg_b),  32'(mb_chg));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Applies a change on d at a falling edge and counts the edges until the
  // selected q bit shows the new value.
  task automatic measure_latency(input bit sel_b, input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((sel_b ? q_b[0] : q_a[0]) !== 1'b1) && n < max_cyc);
  endtask

  // Drives bit 1 of d_a high for len cycles, then watches the outputs.
  task automatic glitch_a(input int len, output int hi_cyc, output int rises, output int falls);
    hi_cyc = 0; rises = 0; falls = 0;
    d_a = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == len - 1) d_a = 4'b0001;
      if (q_a[1])    hi_cyc++;
      if (rise_a[1]) rises++;
      if (fall_a[1]) falls++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, hi, r, f, hold;
    // Reset is held while d_b=11 and d_a is off its reset value. No pulses
    // are expected, and q stays at RESET_VAL.
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    wait_cycles(3);
    check("rst_q_b", 32'(q_b), 32'(B_RV));
    check("rst_q_a", 32'(q_a), 32'(A_RV));
    check("rst_chg_b", 32'(chg_b), 32'd0);
    rst_n = 1'b1;
    // With STAGES=2 and FILTER=0, q_b goes high 2 edges after release.
    wait_cycles(1);
    check("rel_q_b_1", 32'(q_b), 32'd0);
    wait_cycles(1);
    check("rel_q_b_2", 32'(q_b), 32'd3);
    check("rel_rise_b", 32'(rise_b), EDGE_EN ? 32'd3 : 32'd0);
    wait_cycles(1);
    check("rel_rise_b_once", 32'(rise_b), 32'd0);

    // Randomised phase. Values are held for random lengths, and a short
    // reset pulse is applied from time to time.
    for (int it = 0; it < 250; it++) begin
      d_a  = 4'($urandom_range(0, 15));
      d_b  = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 7);
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        wait_cycles($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      wait_cycles(hold);
    end

    // Latency: the input changes before E0, and q is visible after
    // STAGES+FILTER edges.
    d_a = 4'b0000; d_b = 2'b00;
    wait_cycles(12);
    d_a = 4'b0001;
    measure_latency(1'b0, 30, n);
    check("lat_a", 32'(n), 32'(A_ST + A_F));
    d_b = 2'b01;
    measure_latency(1'b1, 30, n);
    check("lat_b", 32'(n), 32'(B_ST + B_F));
    wait_cycles(10);

    // Glitch: a pulse of FILTER cycles is dropped. A pulse of FILTER+1
    // cycles passes and holds q high for FILTER+1 cycles.
    glitch_a(A_F, hi, r, f);
    check("glitch_short_hi", 32'(hi), 32'd0);
    check("glitch_short_rise", 32'(r), 32'd0);
    glitch_a(A_F + 1, hi, r, f);
    check("glitch_long_hi", 32'(hi), 32'(A_F + 1));
    check("glitch_long_rise", 32'(r), EDGE_EN ? 32'd1 : 32'd0);
    check("glitch_long_fall", 32'(f), EDGE_EN ? 32'd1 : 32'd0);

    // Reset mid-count. The count restarts, and the filter then needs
    // FILTER+1 cycles of s high again.
    d_a = 4'b0000;
    wait_cycles(12);
    d_a = 4'b0100;
    wait_cycles(A_ST + 1);
    rst_n = 1'b0;
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(A_ST + A_F + 2);
    check("midrst_q_a", 32'(q_a[2]), 32'd1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
